// File: rtl/fic2_apb_sram_pkg.sv
// Shared constants for the FIC_2 APB SRAM responder:
// register offsets, FSM state codes, error counter width, pointer width helper.
package fic2_apb_sram_pkg;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_PTR     = 8'h08;
    localparam logic [7:0] OFF_DATA    = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH = 8'h10;
    localparam logic [7:0] OFF_ERRCLR  = 8'h14;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_MEMWAIT = 2'd2;

    localparam int ERRCNT_W = 8;

    // Bits needed to index depth words (never less than 1).
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fic2_apb_sram_responder_sram.sv
// Single-port synchronous RAM, 32-bit, 1-cycle read, write-first.
// Ports: clk, en, we, addr, wdata in; rdata out (registered).
module sram_1rw #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/fic2_apb_sram_responder.sv
// APB3 completer: CTRL/STATUS/PTR/DATA/SCRATCH/ERRCLR regs plus SRAM window.
// Ports: PCLK, PRESET, APB PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY/PSLVERR, CTRL_OUT out.
module fic2_apb_sram_responder
    import fic2_apb_sram_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter int          MEM_DEPTH  = 64,
    parameter int unsigned MEM_BASE   = 32'h0100
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [7:0]            CTRL_OUT
);

    localparam int PW = ptr_width(MEM_DEPTH);

    logic [1:0]          state;
    logic [7:0]          ctrl;
    logic [PW-1:0]       ptr;
    logic [31:0]         scratch;
    logic [ERRCNT_W-1:0] errcnt;
    logic                last_err;
    logic                rd_is_data;

    logic [ADDR_WIDTH-1:0] a;
    logic [31:0]           a32;
    logic [31:0]           moff;
    logic [PW-1:0]         mem_idx;
    logic hit_ctrl, hit_status, hit_ptr, hit_data;
    logic hit_scratch, hit_errclr, hit_mem;
    logic mapped, is_err, is_memrd, acc;
    logic [31:0] reg_rdata;
    logic        sram_en, sram_we;
    logic [PW-1:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        unused_bits;

    assign a   = {PADDR[ADDR_WIDTH-1:2], 2'b00};
    assign a32 = 32'(a);

    assign hit_ctrl    = (a == ADDR_WIDTH'(OFF_CTRL));
    assign hit_status  = (a == ADDR_WIDTH'(OFF_STATUS));
    assign hit_ptr     = (a == ADDR_WIDTH'(OFF_PTR));
    assign hit_data    = (a == ADDR_WIDTH'(OFF_DATA));
    assign hit_scratch = (a == ADDR_WIDTH'(OFF_SCRATCH));
    assign hit_errclr  = (a == ADDR_WIDTH'(OFF_ERRCLR));
    assign hit_mem     = (a32 >= MEM_BASE) &&
                         (a32 < MEM_BASE + 32'(4 * MEM_DEPTH));

    assign moff    = a32 - MEM_BASE;
    assign mem_idx = moff[PW+1:2];

    assign unused_bits = ^{PADDR[1:0], moff};

    assign mapped = hit_ctrl | hit_status | hit_ptr | hit_data |
                    hit_scratch | hit_errclr | hit_mem;
    assign is_err = !mapped ||
                    (PWRITE && hit_status) ||
                    (!PWRITE && hit_errclr);
    assign is_memrd = !PWRITE && (hit_mem || hit_data);
    assign acc = (state == S_ACCESS) && PSEL && PENABLE;

    // SRAM is driven directly in the access cycle; reads land in MEMWAIT.
    assign sram_en   = acc && !is_err && (hit_mem || hit_data);
    assign sram_we   = sram_en && PWRITE;
    assign sram_addr = hit_data ? ptr : mem_idx;

    sram_1rw #(
        .DEPTH(MEM_DEPTH),
        .AW   (PW)
    ) u_sram (
        .clk  (PCLK),
        .en   (sram_en),
        .we   (sram_we),
        .addr (sram_addr),
        .wdata(PWDATA),
        .rdata(sram_rdata)
    );

    always_comb begin
        reg_rdata = '0;
        unique case (1'b1)
            hit_ctrl:    reg_rdata = {24'b0, ctrl};
            hit_status:  reg_rdata = {15'b0, last_err, errcnt, 8'(ptr)};
            hit_ptr:     reg_rdata = 32'(ptr);
            hit_scratch: reg_rdata = scratch;
            default:     reg_rdata = '0;
        endcase
    end

    always_comb begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if (!PRESET) begin
            if (acc) begin
                if (is_err)        PSLVERR = 1'b1;
                else if (is_memrd) PREADY  = 1'b0;
                else if (!PWRITE)  PRDATA  = reg_rdata;
            end else if (state == S_MEMWAIT && PSEL) begin
                PRDATA = sram_rdata;
            end
        end
    end

    assign CTRL_OUT = ctrl;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= S_IDLE;
            ctrl       <= '0;
            ptr        <= '0;
            scratch    <= '0;
            errcnt     <= '0;
            last_err   <= 1'b0;
            rd_is_data <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        state <= S_IDLE;
                    end else if (PENABLE) begin
                        if (is_err) begin
                            state    <= S_IDLE;
                            last_err <= 1'b1;
                            if (errcnt != '1) errcnt <= errcnt + 1'b1;
                        end else if (is_memrd) begin
                            state      <= S_MEMWAIT;
                            rd_is_data <= hit_data;
                        end else begin
                            state    <= S_IDLE;
                            last_err <= 1'b0;
                            if (PWRITE) begin
                                if (hit_ctrl)    ctrl    <= PWDATA[7:0];
                                if (hit_ptr)     ptr     <= PWDATA[PW-1:0];
                                if (hit_scratch) scratch <= PWDATA;
                                if (hit_errclr)  errcnt  <= '0;
                            end
                            if (hit_data && ctrl[0]) ptr <= ptr + PW'(1);
                        end
                    end
                end
                S_MEMWAIT: begin
                    state <= S_IDLE;
                    // Dropped PSEL cancels the read: no pointer step.
                    if (PSEL) begin
                        last_err <= 1'b0;
                        if (rd_is_data && ctrl[0]) ptr <= ptr + PW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fic2_apb_sram_responder.sv
// Scoreboard bench for fic2_apb_sram_responder: directed APB transfers,
// expected completions queued at issue, checked by an independent monitor.
module tb_fic2_apb_sram_responder;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  CTRL_OUT;

    always #5 PCLK = ~PCLK;

    fic2_apb_sram_responder dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .CTRL_OUT(CTRL_OUT)
    );

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        err;
        int          w;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int waits = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: counts wait states and checks each completion.
    always @(negedge PCLK) begin
        exp_t e;
        if (PRESET || !PSEL) begin
            waits = 0;
        end else if (PENABLE) begin
            if (!PREADY) begin
                waits++;
            end else if (q.size() == 0) begin
                chk("unexpected completion", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({e.nm, " rdata"}, PRDATA, e.rd);
                chk({e.nm, " slverr"}, 32'(PSLVERR), 32'(e.err));
                chk({e.nm, " waits"}, 32'(waits), 32'(e.w));
                waits = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 so transfers chain back to back.
    task automatic apb(input string nm, input logic wr,
                       input logic [15:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err, input int w);
        exp_t e;
        bit   done;
        e.nm = nm; e.rd = rd; e.err = err; e.w = w;
        q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge PCLK);
            done = PREADY;
        end
        if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [15:0] addr,
                      input logic [31:0] d);
        apb(nm, 1'b1, addr, d, 32'h0, 1'b0, 0);
    endtask

    task automatic rd(input string nm, input logic [15:0] addr,
                      input logic [31:0] exp, input int w);
        apb(nm, 1'b0, addr, 32'h0, exp, 1'b0, w);
    endtask

    task automatic er(input string nm, input logic w_n,
                      input logic [15:0] addr);
        apb(nm, w_n, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset pready", 32'(PREADY), 32'd1);
        chk("reset prdata", PRDATA, 32'h0);
        chk("reset pslverr", 32'(PSLVERR), 32'd0);
        chk("reset ctrl_out", 32'(CTRL_OUT), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        rd("status after reset", 16'h0004, 32'h0, 0);
        wr("win write 0x10c", 16'h010C, 32'hA5A5_0001);
        rd("win read 0x10c", 16'h010C, 32'hA5A5_0001, 1);

        wr("ctrl autoinc", 16'h0000, 32'h0000_0001);
        rd("ctrl read", 16'h0000, 32'h0000_0001, 0);
        chk("ctrl_out", 32'(CTRL_OUT), 32'h1);
        wr("ptr masked", 16'h0008, 32'hFFFF_FF3F);
        rd("ptr read", 16'h0008, 32'd63, 0);
        wr("data 0x11", 16'h000C, 32'h11);
        wr("data 0x22", 16'h000C, 32'h22);
        rd("status ptr wrap", 16'h0004, 32'h0000_0001, 0);
        rd("win sram63", 16'h01FC, 32'h11, 1);
        rd("win sram0", 16'h0100, 32'h22, 1);
        wr("win sram1", 16'h0104, 32'hDEAD_BEEF);
        rd("data read inc", 16'h000C, 32'hDEAD_BEEF, 1);
        rd("status ptr 2", 16'h0004, 32'h0000_0002, 0);
        wr("scratch write", 16'h0010, 32'h1234_5678);
        rd("scratch read", 16'h0010, 32'h1234_5678, 0);

        er("unmapped 0x40", 1'b0, 16'h0040);
        er("status write", 1'b1, 16'h0004);
        rd("status 2 errs", 16'h0004, 32'h0001_0202, 0);
        rd("status ok bit", 16'h0004, 32'h0000_0202, 0);
        er("errclr read", 1'b0, 16'h0014);
        er("above window", 1'b1, 16'h0200);
        er("below window", 1'b0, 16'h00FC);
        rd("sram0 untouched", 16'h0100, 32'h22, 1);
        rd("status 5 errs", 16'h0004, 32'h0000_0502, 0);
        wr("errclr", 16'h0014, 32'h0);
        rd("status cleared", 16'h0004, 32'h0000_0002, 0);

        for (int i = 0; i < 300; i++) er("sat unmapped", 1'b0, 16'h0040);
        rd("status saturated", 16'h0004, 32'h0001_FF02, 0);

        // Aborted DATA read: PSEL drops while in MEMWAIT.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h000C;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("abort wait state", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("abort prdata", PRDATA, 32'h0);
        @(posedge PCLK); #1;
        rd("status after abort", 16'h0004, 32'h0000_FF02, 0);

        // Reset while in MEMWAIT.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0100;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("midreset pready", 32'(PREADY), 32'd1);
        chk("midreset prdata", PRDATA, 32'h0);
        chk("midreset ctrl_out", 32'(CTRL_OUT), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        rd("status post reset", 16'h0004, 32'h0, 0);
        rd("ctrl post reset", 16'h0000, 32'h0, 0);
        rd("sram kept", 16'h0100, 32'h22, 1);

        repeat (2) @(posedge PCLK);
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
